// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared constants and decode record for the posit to binary32 converter
package posit_pkg;

  localparam int          FP32_BIAS = 127;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // k is a two's complement regime value; e is zero-extended when ES < 2
  typedef struct packed {
    logic        sign;
    logic        zero;
    logic        nar;
    logic [5:0]  k;
    logic [1:0]  e;
    logic [22:0] frac;
  } decode_t;

endpackage

// File: rtl/posit_regime_decode.sv
// rtl/posit_regime_decode.sv - leading-run counter turning a posit body into regime value k and run length
module posit_regime_decode #(
  parameter int N = 16
) (
  input  logic [N-2:0]      body,
  output logic signed [5:0] k,
  output logic [4:0]        run
);

  logic lead;
  logic stop;

  assign lead = body[N-2];

  always_comb begin
    run  = '0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && (body[i] == lead)) begin
        run = run + 5'd1;
      end else begin
        stop = 1'b1;
      end
    end
    k = lead ? ($signed({1'b0, run}) - 6'sd1) : -$signed({1'b0, run});
  end

endmodule

// File: rtl/posit_to_fp32_pipe.sv
// rtl/posit_to_fp32_pipe.sv - two-stage valid/ready pipeline converting posit<N,ES> to exact binary32
module posit_to_fp32_pipe
  import posit_pkg::*;
#(
  parameter int N     = 16,
  parameter int ES    = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_posit,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_fp32,
  output logic             out_zero,
  output logic             out_nar,
  output logic [TAG_W-1:0] out_tag
);

  generate
    if (N < 8 || N > 24 || ES < 0 || ES > 2 || TAG_W < 1) begin : g_param_check
      $error("posit_to_fp32_pipe: N must be 8..24, ES 0..2, TAG_W >= 1");
    end
  endgenerate

  logic             sign;
  logic [N-2:0]     body;
  logic [N-2:0]     tail;
  logic signed [5:0] k;
  logic [4:0]       run;
  logic [1:0]       e;
  logic [22:0]      frac;
  decode_t          d_in;

  logic             s1_v;
  decode_t          s1_d;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_v;
  logic             s1_en;
  logic             s2_en;
  logic [7:0]       biased;
  logic [31:0]      fp_next;

  // Decode: NaR negation is harmless here because the nar flag overrides the result.
  assign sign = in_posit[N-1];
  assign body = sign ? -in_posit[N-2:0] : in_posit[N-2:0];

  posit_regime_decode #(.N(N)) u_regime (
    .body (body),
    .k    (k),
    .run  (run)
  );

  // Drop the run plus its terminator; a full-length run shifts everything out.
  assign tail = body << (run + 5'd1);

  generate
    if (ES == 0) begin : g_no_exp
      assign e = 2'b00;
    end else begin : g_exp
      assign e = 2'(tail[N-2 -: ES]);
    end
  endgenerate

  assign frac = 23'(tail[N-2-ES:0]) << (24 - N + ES);

  always_comb begin
    d_in      = '0;
    d_in.sign = sign;
    d_in.zero = (in_posit == '0);
    d_in.nar  = sign && (in_posit[N-2:0] == '0);
    d_in.k    = k;
    d_in.e    = e;
    d_in.frac = frac;
  end

  assign s2_en    = !s2_v || out_ready;
  assign s1_en    = !s1_v || s2_en;
  assign in_ready = s1_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_d   <= '0;
      s1_tag <= '0;
    end else if (s1_en) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_d   <= d_in;
        s1_tag <= in_tag;
      end
    end
  end

  // Exponent fits 1..254 for every legal N/ES, so the low 8 bits of the sum are exact.
  assign biased = ({{2{s1_d.k[5]}}, s1_d.k} << ES) + {6'b0, s1_d.e} + 8'(FP32_BIAS);

  always_comb begin
    fp_next = {s1_d.sign, biased, s1_d.frac};
    if (s1_d.nar) begin
      fp_next = FP32_QNAN;
    end else if (s1_d.zero) begin
      fp_next = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      out_fp32 <= '0;
      out_zero <= 1'b0;
      out_nar  <= 1'b0;
      out_tag  <= '0;
    end else if (s2_en) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_fp32 <= fp_next;
        out_zero <= s1_d.zero;
        out_nar  <= s1_d.nar;
        out_tag  <= s1_tag;
      end
    end
  end

  assign out_valid = s2_v;

endmodule
